// File: rtl/modbus_uart_rx_pkg.sv
// Shared definitions for the Modbus RTU serial link: character receive FSM
// states, link-level receive/send states and framing defaults.
package modbus_uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int CHAR_BITS            = 11;
  // 3.5 characters of 11 bits, rounded up to whole bit-times
  localparam int DEFAULT_SILENCE_BITS = 39;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    RCV_IDLE,
    RCV_RECEIVING,
    RCV_CHECKING
  } rcv_state_e;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_EMITTING,
    SND_SILENCE
  } snd_state_e;

  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       pbit,
                                           input logic       odd);
    return ((^data) ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// lets idle-high lines come out of reset without a spurious edge.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/modbus_uart_rx.sv
// Modbus RTU character receiver: samples the serial line mid-bit, holds one
// byte for the consumer and flags parity/framing errors, overruns and silence.
module modbus_uart_rx
  import modbus_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int SILENCE_BITS = DEFAULT_SILENCE_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [8:0] dataIn,
  output logic       dataReceived,
  output logic       parityError,
  output logic       overflow,
  output logic       silence,
  input  logic       receiveReq
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int SW = $clog2(SILENCE_BITS + 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
  localparam logic [SW-1:0] SIL_MAX  = SW'(SILENCE_BITS);

  rx_state_e     state;
  logic          rx_s;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          pbit;
  logic [SW-1:0] sil_cnt;
  logic          req_q;
  logic          expire;
  logic          ack;
  logic          load;
  logic          perr;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= SIL_MAX) ? SIL_MAX : v + SW'(1);
  endfunction

  sync2 #(
    .RESET_VAL(1'b1)
  ) u_rxd_sync (
    .clk(clk),
    .rst(rst),
    .d  (rxd),
    .q  (rx_s)
  );

  assign expire = (timer == TW'(1));
  assign ack    = receiveReq & ~req_q;
  assign load   = (state == STOP) && expire;
  assign perr   = (PARITY_EN != 0) && parity_mismatch(shreg, pbit, (PARITY_ODD != 0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      pbit    <= 1'b0;
      sil_cnt <= '0;
      silence <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            timer   <= HALF_BIT;
            sil_cnt <= '0;
            silence <= 1'b0;
          end else if (timer == '0) begin
            // only reachable straight out of reset: start the first bit-time
            timer <= FULL_BIT;
          end else if (expire) begin
            timer   <= FULL_BIT;
            sil_cnt <= sat_inc(sil_cnt);
            silence <= (sat_inc(sil_cnt) == SIL_MAX);
          end else begin
            timer <= timer - TW'(1);
          end
        end
        START: begin
          if (expire) begin
            timer   <= FULL_BIT;
            bit_cnt <= '0;
            pbit    <= 1'b0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DATA: begin
          if (expire) begin
            timer   <= FULL_BIT;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        PARITY: begin
          if (expire) begin
            timer <= FULL_BIT;
            pbit  <= rx_s;
            state <= STOP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STOP: begin
          if (expire) begin
            // silence is measured from the stop-bit sample
            timer   <= FULL_BIT;
            sil_cnt <= '0;
            silence <= 1'b0;
            state   <= rx_s ? IDLE : WAIT_HIGH;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            timer <= FULL_BIT;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataIn       <= '0;
      dataReceived <= 1'b0;
      parityError  <= 1'b0;
      overflow     <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      req_q <= receiveReq;
      if (load) begin
        // a new byte always wins over a coincident acknowledge
        dataIn       <= {pbit, shreg};
        parityError  <= perr | ~rx_s;
        dataReceived <= 1'b1;
        overflow     <= ~ack & (overflow | dataReceived);
      end else if (ack) begin
        dataReceived <= 1'b0;
        overflow     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modbus_uart_rx.sv
// Directed bench for modbus_uart_rx: framing, parity, overflow, silence timing
// and reset behaviour with hand-computed expectations.
module tb_modbus_uart_rx;

  localparam int CPB = 16;
  localparam int SIL = 39;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       receiveReq = 1'b0;
  logic [8:0] dataIn;
  logic       dataReceived;
  logic       parityError;
  logic       overflow;
  logic       silence;

  int checks = 0;
  int errors = 0;

  modbus_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .PARITY_EN   (1),
    .PARITY_ODD  (0),
    .SILENCE_BITS(SIL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .dataIn      (dataIn),
    .dataReceived(dataReceived),
    .parityError (parityError),
    .overflow    (overflow),
    .silence     (silence),
    .receiveReq  (receiveReq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_head(input logic [7:0] d, input logic p);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_head(d, p);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b0;
    rxd = 1'b1;
    tick(3);
    checks++;
    if ({dataIn, dataReceived, parityError, overflow, silence} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000", {dataIn, dataReceived, parityError, overflow, silence});
    end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (silence !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n < SIL * CPB || n > SIL * CPB + 2) begin
      errors++;
      $display("FAIL reset_silence_delay: got %0d clocks expected %0d..%0d", n, SIL * CPB, SIL * CPB + 2);
    end
  endtask

  task automatic test_good_frame;
    send_frame(8'h37, 1'b1, 1'b1);
    checks++;
    if (dataIn !== 9'h137) begin
      errors++;
      $display("FAIL good_data: got %h expected 137", dataIn);
    end
    checks++;
    if ({dataReceived, parityError, overflow, silence} !== 4'b1000) begin
      errors++;
      $display("FAIL good_flags: got %b expected 1000", {dataReceived, parityError, overflow, silence});
    end
    tick(20);
    checks++;
    if (dataReceived !== 1'b1) begin
      errors++;
      $display("FAIL good_held: got %b expected 1", dataReceived);
    end
    receiveReq = 1'b1;
    tick(1);
    checks++;
    if ({dataReceived, dataIn} !== {1'b0, 9'h137}) begin
      errors++;
      $display("FAIL good_ack: got %b/%h expected 0/137", dataReceived, dataIn);
    end
    receiveReq = 1'b0;
    tick(1);
  endtask

  task automatic test_silence_glitch;
    int n;
    send_head(8'h37, 1'b1);
    rxd = 1'b1;
    n = 0;
    while (dataReceived !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (dataReceived !== 1'b1) begin
      errors++;
      $display("FAIL sil_frame_load: got %b expected 1", dataReceived);
    end
    receiveReq = 1'b1;
    tick(1);
    receiveReq = 1'b0;
    tick(SIL * CPB - 2);
    checks++;
    if (silence !== 1'b0) begin
      errors++;
      $display("FAIL sil_623: got %b expected 0", silence);
    end
    tick(1);
    checks++;
    if (silence !== 1'b1) begin
      errors++;
      $display("FAIL sil_624: got %b expected 1", silence);
    end
    // 5-clock low glitch
    rxd = 1'b0;
    tick(3);
    checks++;
    if (silence !== 1'b0) begin
      errors++;
      $display("FAIL sil_drop: got %b expected 0", silence);
    end
    tick(2);
    rxd = 1'b1;
    n = 2;
    while (silence !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n < SIL * CPB || n > SIL * CPB + CPB) begin
      errors++;
      $display("FAIL glitch_silence_delay: got %0d clocks expected %0d..%0d", n, SIL * CPB, SIL * CPB + CPB);
    end
    checks++;
    if (dataReceived !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_byte: got %b expected 0", dataReceived);
    end
  endtask

  task automatic test_parity_error;
    receiveReq = 1'b1;
    tick(1);
    send_frame(8'h37, 1'b0, 1'b1);
    checks++;
    if ({dataReceived, parityError, dataIn} !== {2'b11, 9'h037}) begin
      errors++;
      $display("FAIL parity_bad: got %b/%b/%h expected 1/1/037", dataReceived, parityError, dataIn);
    end
    receiveReq = 1'b0;
    tick(1);
    receiveReq = 1'b1;
    tick(1);
    receiveReq = 1'b0;
    checks++;
    if (dataReceived !== 1'b0) begin
      errors++;
      $display("FAIL parity_ack: got %b expected 0", dataReceived);
    end
    send_frame(8'h06, 1'b0, 1'b0);
    checks++;
    if ({dataReceived, parityError, dataIn} !== {2'b11, 9'h006}) begin
      errors++;
      $display("FAIL framing_err: got %b/%b/%h expected 1/1/006", dataReceived, parityError, dataIn);
    end
    receiveReq = 1'b1;
    tick(1);
    receiveReq = 1'b0;
    tick(40 * CPB);
    checks++;
    if ({dataReceived, silence} !== 2'b00) begin
      errors++;
      $display("FAIL break_hold: got %b expected 00", {dataReceived, silence});
    end
    rxd = 1'b1;
    tick(2 * CPB);
    send_frame(8'h06, 1'b0, 1'b1);
    checks++;
    if ({dataReceived, parityError, dataIn} !== {2'b10, 9'h006}) begin
      errors++;
      $display("FAIL break_recover: got %b/%b/%h expected 1/0/006", dataReceived, parityError, dataIn);
    end
    receiveReq = 1'b1;
    tick(1);
    receiveReq = 1'b0;
    tick(1);
  endtask

  task automatic test_overflow;
    send_frame(8'h37, 1'b1, 1'b1);
    send_frame(8'h06, 1'b0, 1'b1);
    checks++;
    if (dataIn !== 9'h006) begin
      errors++;
      $display("FAIL ovf_data: got %h expected 006", dataIn);
    end
    checks++;
    if ({dataReceived, overflow, parityError} !== 3'b110) begin
      errors++;
      $display("FAIL ovf_flags: got %b expected 110", {dataReceived, overflow, parityError});
    end
    receiveReq = 1'b1;
    tick(1);
    receiveReq = 1'b0;
    checks++;
    if ({dataReceived, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL ovf_ack: got %b expected 00", {dataReceived, overflow});
    end
    tick(1);
  endtask

  task automatic test_ack_load_collision;
    send_frame(8'hA5, 1'b0, 1'b1);
    // stop sample lands 11 clocks after the parity bit ends
    send_head(8'h37, 1'b1);
    rxd = 1'b1;
    tick(10);
    receiveReq = 1'b1;
    tick(1);
    receiveReq = 1'b0;
    checks++;
    if ({dataReceived, overflow, dataIn} !== {2'b10, 9'h137}) begin
      errors++;
      $display("FAIL collision: got %b/%b/%h expected 1/0/137", dataReceived, overflow, dataIn);
    end
    tick(CPB);
    send_frame(8'hA5, 1'b0, 1'b1);
    checks++;
    if ({dataReceived, overflow} !== 2'b11) begin
      errors++;
      $display("FAIL collision_ovf: got %b expected 11", {dataReceived, overflow});
    end
  endtask

  task automatic test_reset_mid_frame;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({dataIn, dataReceived, parityError, overflow, silence} !== 13'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0000", {dataIn, dataReceived, parityError, overflow, silence});
    end
    rxd = 1'b1;
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    tick(2 * CPB);
    send_frame(8'hA5, 1'b0, 1'b1);
    checks++;
    if ({dataReceived, parityError, overflow, dataIn} !== {3'b100, 9'h0A5}) begin
      errors++;
      $display("FAIL after_reset: got %b/%b/%b/%h expected 1/0/0/0a5", dataReceived, parityError, overflow, dataIn);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_silence_glitch();
    test_parity_error();
    test_overflow();
    test_ack_load_collision();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modbus_uart_rx.md
MODBUS_UART_RX -- requirements
Module: modbus_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16; clk cycles per UART bit, minimum 4.
REQ-002 SHALL have parameter PARITY_EN, default 1; 1 = parity bit present.
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 = even, 1 = odd.
REQ-004 SHALL have parameter SILENCE_BITS, default 39; idle bit-times that define inter-frame silence (3.5 chars x 11 bits, rounded up).
REQ-005 SHALL have port clk, input, 1; single clock, driven by the consumer's uartClk.
REQ-006 SHALL have port rst, input, 1; reset, asynchronous and active-low.
REQ-007 SHALL have port rxd, input, 1; asynchronous serial line, idle high.
REQ-008 SHALL have port dataIn, output, 9; [7:0] received byte, [8] received parity bit (0 when PARITY_EN=0).
REQ-009 SHALL have port dataReceived, output, 1; holding register valid.
REQ-010 SHALL have port parityError, output, 1; the held byte had a parity or stop-bit (framing) error.
REQ-011 SHALL have port overflow, output, 1; a byte was overwritten before it was acknowledged.
REQ-012 SHALL have port silence, output, 1; line idle for at least SILENCE_BITS bit-times.
REQ-013 SHALL have port receiveReq, input, 1; consumer acknowledge for the held byte.

Function
REQ-014 SHALL pass rxd through a two-flop synchronizer; all decisions use the synchronized value.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-016 IDLE->START SHALL occur on synchronized rxd = 0; the bit timer loads CLKS_PER_BIT/2.
REQ-017 In START, at timer expiry, rxd = 1 SHALL return the FSM to IDLE (false start, no output change); rxd = 0 SHALL go to DATA with the timer reloaded to CLKS_PER_BIT.
REQ-018 In DATA, 8 samples SHALL be taken one per CLKS_PER_BIT, LSB first; the FSM then goes to PARITY if PARITY_EN = 1, else to STOP.
REQ-019 PARITY SHALL sample one bit; the parity error condition is XOR(data, pbit) != PARITY_ODD.
REQ-020 STOP SHALL sample one bit; on the next clk edge the holding register loads dataIn, and parityError is set to (parity error OR stop = 0).
REQ-021 After STOP, the FSM SHALL go to IDLE if stop = 1, else to WAIT_HIGH; WAIT_HIGH exits to IDLE only when rxd = 1 (break handling).
REQ-022 dataReceived SHALL assert on the same edge the holding register loads, and stay high until acknowledged.
REQ-023 Acknowledge SHALL be a rising edge of receiveReq (receiveReq = 1 now, 0 on the previous edge); it clears dataReceived and overflow on that edge.
REQ-024 If a new byte loads while dataReceived = 1, the new byte SHALL overwrite the old one and overflow SHALL set; if ack and load coincide, the load wins: dataReceived = 1, overflow = 0.
REQ-025 The silence counter SHALL count bit-times while the FSM is in IDLE, starting from the stop-bit sample, saturating at SILENCE_BITS.
REQ-026 silence SHALL be 1 exactly while the silence counter = SILENCE_BITS.
REQ-027 Entry to START SHALL clear the silence counter and silence on that edge, including false starts.
REQ-028 Bit timer width SHALL be clog2(CLKS_PER_BIT)+1; silence counter width SHALL be clog2(SILENCE_BITS+1); neither wraps.

Reset
REQ-029 On rst = 0, the FSM SHALL go to IDLE and the synchronizer flops to 1, and dataIn, dataReceived, parityError, overflow, silence and all counters SHALL be 0.
REQ-030 A frame in progress when reset asserts SHALL be discarded; after release, silence first asserts SILENCE_BITS bit-times later.

Structure
REQ-031 FSM state encodings and the default SILENCE_BITS SHALL live in the shared modbus package/include alongside the receive/send state constants.
REQ-032 The synchronizer SHALL be a sub-module named sync2, reusable for other asynchronous inputs.

Verification
REQ-033 Frame 0x37 with even parity (pbit = 1), CLKS_PER_BIT = 16 -> dataIn = 9'h137, parityError = 0, dataReceived high until a receiveReq rising edge, low the edge after.
REQ-034 0x37 with pbit = 0 -> dataIn = 9'h037, parityError = 1; frame 0x06 with stop = 0 and line held low 40 bits -> parityError = 1, no further bytes until the line returns high.
REQ-035 Two frames 0x37 then 0x06 with no ack -> dataIn = 9'h006, overflow = 1; an ack then clears both dataReceived and overflow.
REQ-036 A 5-clock low glitch on rxd -> no dataReceived, silence drops then re-asserts 39 x 16 = 624 clocks later.
REQ-037 After the stop sample, idle 623 clocks -> silence = 0; at 624 clocks -> silence = 1; a start edge -> silence = 0 within 3 clocks (synchronizer).
REQ-038 rst asserted mid-DATA -> all outputs 0 asynchronously; a clean frame 0xA5 after release -> dataIn = 9'h0A5 (even parity, pbit = 0).
